// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- sequential (bit-serial) barrel-shift replacement.
//
// A single accepted request shifts its operand one bit per clock until the
// requested amount has been applied, then presents the result with a
// one-cycle done pulse. Pass-through and zero-amount requests complete in the
// cycle right after acceptance.
//
// Parameters
//   WIDTH    datapath width in bits (default 32)
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   start    request pulse, only sampled while idle
//   op       00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   data_in  operand, sampled together with start
//   shamt    shift amount 0..31, sampled together with start
//   busy     high whenever an operation is in flight (state not IDLE)
//   done     one-cycle pulse, result valid
//   result   last completed result, held until the next operation completes
// -----------------------------------------------------------------------------
module shift_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sh;
  logic [1:0]       op_q;
  logic [4:0]       cnt;

  // Requests that need no shifting go straight to DONE.
  logic             skip_shift;
  assign skip_shift = (shamt == 5'd0) || (op == OP_PASS);

  // One-bit step of the working register for the latched operation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    acc_sh = acc;
    unique case (op_q)
      OP_SLL:  acc_sh = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_sh = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_sh = acc;
    endcase
  end

  // Next-state logic. start is only looked at in IDLE, so a held or repeated
  // request during SHIFT/DONE has no effect.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = skip_shift ? DONE : SHIFT;
      end
      SHIFT: begin
        // cnt is at least 1 here: a zero amount never enters SHIFT.
        if (cnt == 5'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      op_q   <= OP_SLL;
      cnt    <= 5'd0;
      result <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc  <= data_in;
            op_q <= op;
            cnt  <= shamt;
            // Zero-length operations complete on this edge, so result is
            // loaded now to be valid during the DONE cycle.
            if (skip_shift) result <= data_in;
          end
        end
        SHIFT: begin
          acc <= acc_sh;
          cnt <= cnt - 5'd1;
          // Last step: publish the final value as DONE is entered.
          if (cnt == 5'd1) result <= acc_sh;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq -- self-checking bench for shift_seq.
//
// Each request pushes its expected result and latency into a scoreboard
// queue; the entry is popped and compared when done is observed. Outputs are
// sampled on the falling edge, inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_seq;

  localparam int WIDTH   = 32;
  localparam int MAX_LAT = 100;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [4:0]       shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] last_res;

  shift_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built from the language shift operators.
  function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] d,
                                 input logic [4:0] s);
    exp_t e;
    case (o)
      2'b00:   e.res = d << s;
      2'b01:   e.res = d >> s;
      2'b10:   e.res = WIDTH'($signed(d) >>> s);
      default: e.res = d;
    endcase
    e.lat = (o == 2'b11 || s == 5'd0) ? 1 : int'(s) + 1;
    return e;
  endfunction

  // Issue one request and wait for its done pulse. When hold is set, start
  // stays high and the inputs stay put for the whole operation; otherwise
  // the inputs are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [WIDTH-1:0] d, input logic [4:0] s,
                        input bit hold);
    int   n;
    bit   got;
    exp_t e;
    @(negedge clk);
    check({tag, "_idle_busy"}, WIDTH'(busy), '0);
    check({tag, "_idle_done"}, WIDTH'(done), '0);
    check({tag, "_idle_result"}, result, last_res);
    op = o; data_in = d; shamt = s; start = 1'b1;
    sb.push_back(model(o, d, s));
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < MAX_LAT) begin
      @(negedge clk);
      n++;
      if (!hold) begin
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = WIDTH'($urandom);
        shamt   = 5'($urandom);
      end
      check({tag, "_busy"}, WIDTH'(busy), WIDTH'(1));
      if (done === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout: observed=no_done expected=done_within_%0d", tag, MAX_LAT);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_latency"}, WIDTH'(n), WIDTH'(e.lat));
      last_res = e.res;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = 5'd0;
    last_res = '0;

    // Reset state, with start asserted to show it is ignored under reset.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("rst_busy", WIDTH'(busy), '0);
    check("rst_done", WIDTH'(done), '0);
    check("rst_result", result, '0);
    start = 1'b0;
    rst   = 1'b0;

    // Directed operations.
    run_op("sra_neg_4",  2'b10, 32'h8000_0000, 5'd4,  0);
    run_op("sll_1_31",   2'b00, 32'h0000_0001, 5'd31, 0);
    run_op("srl_1",      2'b01, 32'h8000_0000, 5'd1,  0);
    run_op("sra_zero",   2'b10, 32'h1234_5678, 5'd0,  0);
    run_op("pass_7",     2'b11, 32'hCAFE_F00D, 5'd7,  0);

    // start held high throughout: one completion, then the next request is
    // taken only in the IDLE cycle after DONE.
    run_op("srl_hold",   2'b01, 32'hFFFF_FFFF, 5'd3,  1);
    run_op("srl_again",  2'b01, 32'hFFFF_FFFF, 5'd3,  0);

    // Reset during the second cycle of an SLL by 10.
    @(negedge clk);
    op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", WIDTH'(busy), '0);
    check("abort_done", WIDTH'(done), '0);
    check("abort_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", WIDTH'(done), '0);
    end

    // First request after reset release, then sign extension boundary.
    run_op("sra_m2_31",  2'b10, 32'hFFFF_FFFE, 5'd31, 0);
    run_op("sra_pos_31", 2'b10, 32'h7FFF_FFFF, 5'd31, 0);

    // A few random operations, issued back to back.
    for (int i = 0; i < 6; i++)
      run_op("rand", 2'($urandom), WIDTH'($urandom), 5'($urandom_range(31, 0)), 0);

    @(negedge clk);
    check("final_done", WIDTH'(done), '0);
    check("sb_empty", WIDTH'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
